arp_scheduler: RTL and testbench
================================

// Module: arp_scheduler
// PURPOSE
// - Time-shares the 8 synth voices' key gates under arpeggiator control.
// - Sits between the Avalon control register file and the voice/ADSR datapath.
// - ARP_EN=0: KEY_IN passes straight through (registered).
// - ARP_EN=1: one held key at a time is gated on. The held key advances every ARP_TIME ticks, up-only or ping-pong.
// PARAMETERS
// - NUM_VOICES  8      number of voice key gates (index width IW = $clog2(NUM_VOICES))
// - TICK_DIV    50000  CLK cycles per arp tick (1 ms at 50 MHz); >=2
// - TIME_W      16     width of ARP_TIME
// PORTS
// - CLK          in   1           system clock, all logic on rising edge
// - RESET_N      in   1           synchronous, active-low reset
// - ARP_EN       in   1           arpeggiator enable
// - PINGPONGEN   in   1           1 = bounce at ends, 0 = wrap upward
// - ARP_TIME     in   TIME_W      step length in ticks; 0 treated as 1
// - KEY_IN       in   NUM_VOICES  held-key mask from register file (bit i = KEYi)
// - KEY_OUT      out  NUM_VOICES  gated key mask to voices (registered)
// - STEP_IDX     out  IW          index of currently sounding arp voice
// - STEP_STROBE  out  1           1-cycle pulse when a new arp step begins
// - ACTIVE       out  1           1 while the arp is in PLAY
// BEHAVIOUR
// - Reset (RESET_N=0 at a clock edge): KEY_OUT=0, STEP_IDX=0, STEP_STROBE=0, ACTIVE=0.
//   Also dir=UP, prescaler=0, step_cnt=0, state=IDLE. Reset mid-step aborts immediately.
// - Prescaler: counts 0..TICK_DIV-1 and wraps; tick=1 on the wrap cycle.
//   Free-running while ARP_EN=1; held at 0 while ARP_EN=0.
// - ARP_EN=0: KEY_OUT <= KEY_IN each cycle (1-cycle latency). state=IDLE, ACTIVE=0, STEP_STROBE=0.
// - FSM, IDLE -> PLAY: ARP_EN=1 and KEY_IN!=0.
//   - STEP_IDX <= lowest set index; dir=UP; step_cnt=0.
//   - KEY_OUT <= one-hot(STEP_IDX); STEP_STROBE=1 in the same cycle.
// - FSM, PLAY -> IDLE: KEY_IN==0 or ARP_EN=0.
//   - Next cycle: KEY_OUT=0 (arp) or KEY_IN (passthrough); ACTIVE=0; dir=UP.
// - PLAY: on tick, step_cnt++. Advance when step_cnt+1 >= max(ARP_TIME,1).
//   - ARP_TIME is compared live; lowering it mid-step advances on the next tick.
// - PLAY: if KEY_IN[STEP_IDX] drops, advance on the next cycle without waiting for tick.
//   - Release coinciding with tick yields exactly one advance.
// - Advance (next index from KEY_IN sampled that cycle; step_cnt<=0; STEP_STROBE=1):
//   - UP: next = lowest held > cur.
//     If none: PINGPONGEN ? (dir<=DN, next = highest held < cur) : next = lowest held (wrap).
//   - DN: PINGPONGEN=0 forces dir<=UP and applies the UP rule.
//     Else next = highest held < cur; if none, dir<=UP and next = lowest held > cur.
//   - Single held key: next=cur; STEP_STROBE still pulses (retrigger).
//   - Ping-pong endpoints are not repeated: keys {1,3,5} -> 1,3,5,3,1,3,...
//   - Current key released and no other key held: PLAY -> IDLE rule applies instead.
// - KEY_OUT in PLAY: one-hot(STEP_IDX); never more than one bit set; updated the cycle after an advance.
// - Newly pressed keys join the sequence at their index position; no restart.
// CONFIGURATION
// - Macro ARP_GATE_EN:
//   - Defined: during the final quarter of each step (step_cnt >= ARP_TIME - ARP_TIME/4, with ARP_TIME>=4), KEY_OUT=0.
//     This forces an ADSR release/retrigger between consecutive notes, including the single-held-key case.
//     For ARP_TIME<4 there is no gap.
//   - Undefined: KEY_OUT is held continuously for the full step (legato).
// TESTING (TICK_DIV=4)
// - Reset: hold RESET_N=0 with KEY_IN=8'hFF, ARP_EN=1
//   -> KEY_OUT=0, ACTIVE=0, STEP_STROBE=0; after release, KEY_OUT=8'h01 the next cycle.
// - Passthrough: ARP_EN=0, KEY_IN 8'h00 -> 8'hA5 -> KEY_OUT=8'hA5 exactly 1 cycle later.
//   STEP_STROBE never pulses.
// - Up wrap: ARP_EN=1, PINGPONGEN=0, ARP_TIME=2, KEY_IN=8'h2A -> STEP_IDX 1,3,5,1,...
//   Strobes 8 clocks apart.
// - Ping-pong: PINGPONGEN=1, ARP_TIME=1, KEY_IN=8'h2A -> STEP_IDX 1,3,5,3,1,3, one step per 4 clocks.
// - Release: while at STEP_IDX=3 of 8'h2A, clear bit 3 mid-step -> advance to 5 next cycle, step_cnt=0.
//   Then KEY_IN=0 -> KEY_OUT=0, ACTIVE=0 next cycle.
// - Gate (ARP_GATE_EN): ARP_TIME=8, KEY_IN=8'h10 -> KEY_OUT=8'h10 for ticks 0-5, 8'h00 for ticks 6-7.
//   STEP_STROBE every 32 clocks.

Source files
------------

// File: rtl/arp_scheduler.sv
// arp_scheduler: time-shares the synth voice key gates under arpeggiator control.
// With ARP_EN low the held-key mask passes straight through (registered). With
// ARP_EN high exactly one held key is gated at a time. The gated key advances
// every ARP_TIME ticks, either upward with wrap or ping-pong.
// Optional build macro ARP_GATE_EN silences KEY_OUT during the final quarter of
// each step, so the ADSR releases and retriggers between notes.
module arp_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int TICK_DIV   = 50000,
  parameter int TIME_W     = 16
) (
  input  logic                            CLK,
  input  logic                            RESET_N,
  input  logic                            ARP_EN,
  input  logic                            PINGPONGEN,
  input  logic [TIME_W-1:0]               ARP_TIME,
  input  logic [NUM_VOICES-1:0]           KEY_IN,
  output logic [NUM_VOICES-1:0]           KEY_OUT,
  output logic [$clog2(NUM_VOICES)-1:0]   STEP_IDX,
  output logic                            STEP_STROBE,
  output logic                            ACTIVE
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic {IDLE, PLAY} state_t;
  typedef enum logic {DIR_UP, DIR_DN} dir_t;

  state_t                state, state_nxt;
  dir_t                  dir, dir_nxt;
  logic [PW-1:0]         presc, presc_nxt;
  logic [TIME_W-1:0]     step_cnt, cnt_nxt;
  logic [IW-1:0]         step_idx, idx_nxt;
  logic [NUM_VOICES-1:0] key_out, key_nxt;
  logic                  strobe, strobe_nxt;

  logic                  tick;
  logic                  any_held;
  logic                  cur_held;
  logic                  advance;
  logic                  gap;
  logic [TIME_W:0]       t_eff;
  logic [TIME_W:0]       cnt_plus1;
  logic [IW:0]           above;
  logic [IW:0]           below;
  logic [IW:0]           lowest;

  // Returns {found, index} of the lowest held key strictly above cur.
  function automatic logic [IW:0] find_above(input logic [NUM_VOICES-1:0] keys,
                                             input logic [IW-1:0] cur);
    logic [IW:0] res;
    res = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (keys[i] && (IW'(i) > cur)) res = {1'b1, IW'(i)};
    end
    return res;
  endfunction

  // Returns {found, index} of the highest held key strictly below cur.
  function automatic logic [IW:0] find_below(input logic [NUM_VOICES-1:0] keys,
                                             input logic [IW-1:0] cur);
    logic [IW:0] res;
    res = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (keys[i] && (IW'(i) < cur)) res = {1'b1, IW'(i)};
    end
    return res;
  endfunction

  // Returns {found, index} of the lowest held key overall.
  function automatic logic [IW:0] find_lowest(input logic [NUM_VOICES-1:0] keys);
    logic [IW:0] res;
    res = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (keys[i]) res = {1'b1, IW'(i)};
    end
    return res;
  endfunction

  // Search results and step-length arithmetic used by the next-state logic.
  always_comb begin
    any_held  = |KEY_IN;
    cur_held  = KEY_IN[step_idx];
    tick      = ARP_EN && (presc == PW'(TICK_DIV - 1));
    t_eff     = (ARP_TIME == '0) ? (TIME_W+1)'(1) : {1'b0, ARP_TIME};
    cnt_plus1 = {1'b0, step_cnt} + (TIME_W+1)'(1);
    above     = find_above(KEY_IN, step_idx);
    below     = find_below(KEY_IN, step_idx);
    lowest    = find_lowest(KEY_IN);
  end

  // Next-state, step selection and registered-output values.
  always_comb begin
    state_nxt  = state;
    dir_nxt    = dir;
    cnt_nxt    = step_cnt;
    idx_nxt    = step_idx;
    strobe_nxt = 1'b0;
    key_nxt    = '0;
    advance    = 1'b0;
    gap        = 1'b0;
    presc_nxt  = '0;

    if (ARP_EN) begin
      presc_nxt = tick ? '0 : presc + PW'(1);
    end

    case (state)
      IDLE: begin
        if (ARP_EN && any_held) begin
          state_nxt  = PLAY;
          idx_nxt    = lowest[IW-1:0];
          dir_nxt    = DIR_UP;
          cnt_nxt    = '0;
          strobe_nxt = 1'b1;
        end
      end
      PLAY: begin
        if (!ARP_EN || !any_held) begin
          state_nxt = IDLE;
          dir_nxt   = DIR_UP;
        end else begin
          if (tick) begin
            if (cnt_plus1 >= t_eff) advance = 1'b1;
            else                    cnt_nxt = step_cnt + TIME_W'(1);
          end
          if (!cur_held) advance = 1'b1;

          if (advance) begin
            cnt_nxt    = '0;
            strobe_nxt = 1'b1;
            if (dir == DIR_UP || !PINGPONGEN) begin
              if (above[IW]) begin
                idx_nxt = above[IW-1:0];
                dir_nxt = DIR_UP;
              end else if (PINGPONGEN && below[IW]) begin
                idx_nxt = below[IW-1:0];
                dir_nxt = DIR_DN;
              end else begin
                idx_nxt = lowest[IW-1:0];
                dir_nxt = DIR_UP;
              end
            end else begin
              if (below[IW]) begin
                idx_nxt = below[IW-1:0];
              end else if (above[IW]) begin
                idx_nxt = above[IW-1:0];
                dir_nxt = DIR_UP;
              end else begin
                idx_nxt = lowest[IW-1:0];
                dir_nxt = DIR_UP;
              end
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        dir_nxt   = DIR_UP;
      end
    endcase

`ifdef ARP_GATE_EN
    gap = (ARP_TIME >= TIME_W'(4)) && (cnt_nxt >= (ARP_TIME - (ARP_TIME >> 2)));
`else
    gap = 1'b0;
`endif

    if (!ARP_EN) begin
      key_nxt = KEY_IN;
    end else if (state_nxt == PLAY && !gap) begin
      key_nxt = NUM_VOICES'(1) << idx_nxt;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state    <= IDLE;
      dir      <= DIR_UP;
      presc    <= '0;
      step_cnt <= '0;
      step_idx <= '0;
      key_out  <= '0;
      strobe   <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      presc    <= presc_nxt;
      step_cnt <= cnt_nxt;
      step_idx <= idx_nxt;
      key_out  <= key_nxt;
      strobe   <= strobe_nxt;
    end
  end

  assign KEY_OUT     = key_out;
  assign STEP_IDX    = step_idx;
  assign STEP_STROBE = strobe;
  assign ACTIVE      = (state == PLAY);

endmodule

// File: tb/tb_arp_scheduler.sv
// tb_arp_scheduler: scoreboard bench for arp_scheduler with TICK_DIV=4.
// A reference model derived from the arpeggiator rules queues the expected
// per-cycle KEY_OUT/ACTIVE and every expected step strobe. A separate monitor
// pops those queues and compares them against the DUT outputs.
module tb_arp_scheduler;

  localparam int NV = 8;
  localparam int TD = 4;
  localparam int TW = 16;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          ARP_EN = 1'b1;
  logic          PINGPONGEN = 1'b0;
  logic [TW-1:0] ARP_TIME = 16'd1;
  logic [NV-1:0] KEY_IN = 8'hFF;
  logic [NV-1:0] KEY_OUT;
  logic [2:0]    STEP_IDX;
  logic          STEP_STROBE;
  logic          ACTIVE;

  int total = 0;
  int bad = 0;

  typedef struct { int cyc; int idx; } strobe_t;
  typedef struct { int key; int act; } cyc_t;

  strobe_t strobe_q[$];
  cyc_t    cyc_q[$];

  arp_scheduler #(.NUM_VOICES(NV), .TICK_DIV(TD), .TIME_W(TW)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .ARP_EN(ARP_EN),
    .PINGPONGEN(PINGPONGEN),
    .ARP_TIME(ARP_TIME),
    .KEY_IN(KEY_IN),
    .KEY_OUT(KEY_OUT),
    .STEP_IDX(STEP_IDX),
    .STEP_STROBE(STEP_STROBE),
    .ACTIVE(ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic note_failure(input string name, input int detail);
    total++;
    bad++;
    $display("[TB] FAIL %s: detail %0d at t=%0t", name, detail, $time);
  endtask

  // Reference model: held keys kept as a sorted list, sequencing by the arp rules.
  int m_cyc = 0;
  bit m_play = 1'b0;
  bit m_up = 1'b1;
  int m_cur = 0;
  int m_ticks = 0;
  int m_run = 0;

  always @(posedge CLK) begin
    int held[$];
    int above[$];
    int below[$];
    bit tick;
    bit adv;
    int t_eff;
    int exp_key;
    cyc_t c;

    m_cyc++;
    exp_key = 0;
    if (!RESET_N) begin
      m_play  = 1'b0;
      m_up    = 1'b1;
      m_ticks = 0;
      m_run   = 0;
    end else begin
      held.delete();
      for (int i = 0; i < NV; i++) if (KEY_IN[i]) held.push_back(i);
      tick  = ARP_EN && ((m_run % TD) == TD - 1);
      m_run = ARP_EN ? m_run + 1 : 0;
      t_eff = (ARP_TIME == 0) ? 1 : int'(ARP_TIME);

      if (!m_play) begin
        if (ARP_EN && held.size() > 0) begin
          m_play  = 1'b1;
          m_cur   = held[0];
          m_up    = 1'b1;
          m_ticks = 0;
          strobe_q.push_back('{m_cyc, m_cur});
        end
      end else if (!ARP_EN || held.size() == 0) begin
        m_play = 1'b0;
        m_up   = 1'b1;
      end else begin
        adv = 1'b0;
        if (tick) begin
          if (m_ticks + 1 >= t_eff) adv = 1'b1;
          else m_ticks++;
        end
        if (!KEY_IN[m_cur]) adv = 1'b1;
        if (adv) begin
          above.delete();
          below.delete();
          foreach (held[k]) begin
            if (held[k] > m_cur) above.push_back(held[k]);
            if (held[k] < m_cur) below.push_back(held[k]);
          end
          if (m_up || !PINGPONGEN) begin
            if (above.size() > 0) begin m_cur = above[0]; m_up = 1'b1; end
            else if (PINGPONGEN && below.size() > 0) begin m_cur = below[$]; m_up = 1'b0; end
            else begin m_cur = held[0]; m_up = 1'b1; end
          end else begin
            if (below.size() > 0) m_cur = below[$];
            else if (above.size() > 0) begin m_cur = above[0]; m_up = 1'b1; end
            else begin m_cur = held[0]; m_up = 1'b1; end
          end
          m_ticks = 0;
          strobe_q.push_back('{m_cyc, m_cur});
        end
      end

      if (!ARP_EN) exp_key = int'(KEY_IN);
      else if (m_play) begin
        exp_key = 1 << m_cur;
`ifdef ARP_GATE_EN
        if (ARP_TIME >= 4 && m_ticks >= int'(ARP_TIME) - int'(ARP_TIME) / 4) exp_key = 0;
`endif
      end
    end
    c.key = exp_key;
    c.act = m_play ? 1 : 0;
    cyc_q.push_back(c);
  end

  // Monitor: pops expectations and compares with what the DUT presents.
  int mon_cyc = 0;

  always @(posedge CLK) begin
    cyc_t c;
    strobe_t s;
    #1;
    mon_cyc++;
    if (cyc_q.size() == 0) note_failure("cycle_expectation_missing", mon_cyc);
    else begin
      c = cyc_q.pop_front();
      check_output("key_out", int'(KEY_OUT), c.key);
      check_output("active", int'(ACTIVE), c.act);
    end
    while (strobe_q.size() > 0 && strobe_q[0].cyc < mon_cyc) begin
      s = strobe_q.pop_front();
      note_failure("missed_strobe_cycle", s.cyc);
    end
    if (STEP_STROBE) begin
      if (strobe_q.size() == 0 || strobe_q[0].cyc != mon_cyc) note_failure("unexpected_strobe", mon_cyc);
      else begin
        s = strobe_q.pop_front();
        check_output("step_idx", int'(STEP_IDX), s.idx);
      end
    end
  end

  task automatic apply_stimulus(input bit en, input bit pp, input int t, input int keys, input int n);
    ARP_EN     = en;
    PINGPONGEN = pp;
    ARP_TIME   = TW'(t);
    KEY_IN     = NV'(keys);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  initial begin
    int b;
    bit found;

    // Reset held with keys and arp enabled, then released.
    repeat (3) @(posedge CLK);
    #2;
    RESET_N = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1, 8'hFF, 6);

    // Passthrough.
    apply_stimulus(1'b0, 1'b0, 1, 8'h00, 4);
    apply_stimulus(1'b0, 1'b0, 1, 8'hA5, 6);

    // Upward wrap and ping-pong on keys 1,3,5.
    apply_stimulus(1'b1, 1'b0, 2, 8'h2A, 60);
    apply_stimulus(1'b0, 1'b0, 2, 8'h00, 2);
    apply_stimulus(1'b1, 1'b1, 1, 8'h2A, 40);

    // Mid-step release of the sounding key, then release of everything.
    apply_stimulus(1'b1, 1'b0, 8, 8'h2A, 1);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (ACTIVE && STEP_IDX == 3'd3) found = 1'b1;
      else begin @(posedge CLK); #2; end
    end
    if (!found) note_failure("wait_for_step_idx_3", 400);
    apply_stimulus(1'b1, 1'b0, 8, 8'h2A, 3);
    apply_stimulus(1'b1, 1'b0, 8, 8'h22, 10);
    apply_stimulus(1'b1, 1'b0, 8, 8'h00, 4);

    // Single held key with a long step (gap behaviour depends on build).
    apply_stimulus(1'b1, 1'b0, 8, 8'h10, 100);

    // Randomised traffic.
    apply_stimulus(1'b1, 1'b0, 2, 8'h5A, 1);
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(7) == 0) begin
        b = int'($urandom_range(7));
        KEY_IN[b] = ~KEY_IN[b];
      end
      if ($urandom_range(299) == 0) ARP_EN = ~ARP_EN;
      if (c % 97 == 0) begin
        ARP_TIME = TW'($urandom_range(5));
        if ($urandom_range(3) == 0) ARP_TIME = 16'd8;
        PINGPONGEN = 1'($urandom_range(1));
      end
      RESET_N = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
      @(posedge CLK);
      #2;
    end
    RESET_N = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1, 8'h00, 4);

    @(posedge CLK);
    #3;
    while (strobe_q.size() > 0) begin
      strobe_t s;
      s = strobe_q.pop_front();
      note_failure("strobe_never_seen", s.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
